// File: rtl/four_bit_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with a one-cycle divide-by-zero path.
module four_bit_divider #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             qbit;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] dvd_next;

   // One restoring step; quotient bits fill the dividend register as it empties.
   always_comb begin
      shifted  = {rem[WIDTH-1:0], dvd[WIDTH-1]};
      trial    = shifted - {1'b0, dvs};
      qbit     = ~trial[WIDTH];
      rem_next = qbit ? trial : shifted;
      dvd_next = {dvd[WIDTH-2:0], qbit};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         dvd         <= '0;
         dvs         <= '0;
         rem         <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (B == '0) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= A;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= CALC;
                     busy  <= 1'b1;
                     dvd   <= A;
                     dvs   <= B;
                     rem   <= '0;
                     cnt   <= CW'(WIDTH);
                  end
               end
            end
            CALC: begin
               dvd <= dvd_next;
               rem <= rem_next;
               cnt <= cnt - CW'(1);
               // Last iteration publishes the result directly from the step logic.
               if (cnt == CW'(1)) begin
                  state       <= DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= dvd_next;
                  remainder   <= rem_next[WIDTH-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_four_bit_divider.sv
// Self-checking bench for four_bit_divider: directed cases, random pairs and an
// exhaustive back-to-back sweep against a plain-arithmetic reference.
module tb_four_bit_divider;

   localparam int unsigned W = 4;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int errors;
   int checks;
   int done_total;

   four_bit_divider #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent count of done pulses seen at clock edges.
   always @(posedge clk) if (done === 1'b1) done_total++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts one division and checks latency, busy duration and the result.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      int n;
      int busy_n;
      int exp_q;
      int exp_r;
      int exp_lat;
      int exp_busy;
      logic exp_z;
      if (b == 0) begin
         exp_q = (1 << W) - 1; exp_r = int'(a); exp_z = 1'b1; exp_lat = 1; exp_busy = 0;
      end else begin
         exp_q = int'(a) / int'(b); exp_r = int'(a) % int'(b); exp_z = 1'b0;
         exp_lat = W + 1; exp_busy = W;
      end
      A = a; B = b; start = 1'b1;
      step();
      start = 1'b0;
      A = W'($urandom); B = W'($urandom);
      n = 1; busy_n = 0;
      while (done !== 1'b1 && n <= 20) begin
         if (busy === 1'b1) busy_n++;
         step();
         n++;
      end
      check({tag, " done"}, 32'(done), 32'(1));
      check({tag, " latency"}, 32'(n), 32'(exp_lat));
      check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      check({tag, " busy_at_done"}, 32'(busy), 32'(0));
      check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
      check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
      check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_z));
      step();
      check({tag, " done_pulse_end"}, 32'(done), 32'(0));
   endtask

   initial begin
      int base;
      bit saw;
      errors = 0; checks = 0; done_total = 0;
      reset = 1'b1; start = 1'b0; A = '0; B = '0;
      #12;
      check("reset busy", 32'(busy), 32'(0));
      check("reset done", 32'(done), 32'(0));
      check("reset quotient", 32'(quotient), 32'(0));
      check("reset remainder", 32'(remainder), 32'(0));
      check("reset dbz", 32'(div_by_zero), 32'(0));
      reset = 1'b0;
      step();

      run_div(4'd13, 4'd3, "13/3");
      A = 4'd5; B = 4'd1;
      for (int i = 0; i < 3; i++) step();
      check("hold quotient", 32'(quotient), 32'(4));
      check("hold remainder", 32'(remainder), 32'(1));

      run_div(4'd15, 4'd1, "15/1");
      run_div(4'd2, 4'd5, "2/5");
      run_div(4'd0, 4'd7, "0/7");
      run_div(4'd15, 4'd15, "15/15");
      run_div(4'd9, 4'd0, "9/0");
      run_div(4'd8, 4'd2, "8/2");

      // Second start while busy must be ignored.
      base = done_total;
      A = 4'd12; B = 4'd5; start = 1'b1;
      step();
      A = 4'd7; B = 4'd7;
      step();
      start = 1'b0; A = 4'd3; B = 4'd1;
      for (int i = 0; i < 12; i++) step();
      check("proto quotient", 32'(quotient), 32'(2));
      check("proto remainder", 32'(remainder), 32'(2));
      check("proto done_count", 32'(done_total - base), 32'(1));
      check("proto idle_busy", 32'(busy), 32'(0));

      // Asynchronous reset two cycles into a run.
      A = 4'd14; B = 4'd3; start = 1'b1;
      step();
      start = 1'b0;
      step();
      #2 reset = 1'b1;
      #1;
      check("midreset busy", 32'(busy), 32'(0));
      check("midreset quotient", 32'(quotient), 32'(0));
      check("midreset remainder", 32'(remainder), 32'(0));
      check("midreset dbz", 32'(div_by_zero), 32'(0));
      @(posedge clk);
      #3 reset = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
      end
      check("midreset no_done", 32'(saw), 32'(0));
      run_div(4'd14, 4'd3, "14/3 after reset");

      // Random operands with random idle gaps.
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = W'($urandom_range(0, 15));
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
         run_div(ra, rb, "random");
      end

      // Exhaustive back-to-back sweep.
      base = done_total;
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run_div(W'(a), W'(b), "sweep");
      check("sweep done_count", 32'(done_total - base), 32'(256));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/four_bit_divider.md
# four_bit_divider

Sequential unsigned restoring divider. It computes `quotient = A / B` and `remainder = A % B`, producing one quotient bit per clock behind a start/busy/done handshake. It is the inverse companion of the ALU's combinational 4-bit multiply path and sits beside the ALU `mux` as a multi-cycle operation unit. It is built from the same shift-and-add/subtract primitives as the multiplier.

## Interface
Parameters:
- `WIDTH`, default 4: operand, quotient and remainder width in bits.

Ports:
- `clk`, input, 1: single clock; all state changes occur on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a division. Sampled only in the IDLE state.
- `A`, input, WIDTH: dividend. Captured on the accepting edge.
- `B`, input, WIDTH: divisor. Captured on the accepting edge.
- `busy`, output, 1: high while in the CALC state.
- `done`, output, 1: one-cycle pulse; the result is valid from this cycle onward.
- `quotient`, output, WIDTH: last completed quotient. Held until the next completion.
- `remainder`, output, WIDTH: last completed remainder. Held until the next completion.
- `div_by_zero`, output, 1: set with `done` when the captured B was 0. Held with the result.

## Operation
- The state machine has three states: IDLE, CALC and DONE.
- IDLE, `start`=1, captured B≠0:
  - Load the dividend shift register with A and the divisor register with B.
  - Clear the partial remainder (WIDTH+1 bits) and set the iteration counter to WIDTH.
  - Go to CALC.
- IDLE, `start`=1, captured B=0:
  - Go directly to DONE.
  - Set `quotient` to all ones, `remainder` to A and `div_by_zero` to 1.
- CALC, one iteration per clock:
  - Shift: r = {r[WIDTH-1:0], dividend MSB}, and shift the dividend left by one.
  - Trial: t = r − {0,B}, computed at WIDTH+1 bits.
  - If t is non-negative (MSB=0): r = t and shift a 1 into the quotient LSB.
  - Otherwise: keep r and shift a 0 into the quotient LSB.
  - Decrement the counter. After the WIDTH-th iteration go to DONE and load the `quotient`/`remainder` outputs. Clear `div_by_zero`.
- DONE lasts exactly one cycle with `done`=1, then the block returns to IDLE unconditionally.
- `start` in CALC or DONE is ignored. It is not queued, and the inputs are not re-sampled.
- A and B may change freely after the accepting edge; only the captured copies are used.
- Result invariant: the output registers always satisfy A = quotient·B + remainder, with remainder < B (for B≠0).
- All arithmetic is unsigned. The remainder never exceeds WIDTH bits at completion; the extra bit exists only for the trial subtraction.

## Timing
- Reset (asynchronous, takes effect immediately, independent of `clk`):
  - State goes to IDLE.
  - `busy`, `done`, `quotient`, `remainder` and `div_by_zero` all go to 0.
  - Internal registers are cleared.
- Reset during CALC or DONE aborts the operation. No `done` pulse follows, and the previous result is lost (outputs read 0).
- Normal latency, with the start accepted at edge k:
  - `busy`=1 from edge k through edge k+WIDTH−1.
  - `done`=1 and the result valid for the cycle after edge k+WIDTH.
  - That is WIDTH+1 cycles from start to `done` (5 for WIDTH=4).
- Divide-by-zero latency: `done` and the result appear after edge k, with `busy` never asserted.
- The earliest next accepted start is the edge after the DONE cycle, giving a throughput of one result per WIDTH+2 cycles.
- `busy` and `done` are never high in the same cycle.

## Test plan
- A=13, B=3, `start` pulsed one cycle:
  - `busy` high for 4 cycles.
  - `done` pulse on cycle 5.
  - quotient=4, remainder=1, div_by_zero=0.
  - Outputs hold until the next done.
- Edge operands, run sequentially:
  - 15/1 → q=15, r=0.
  - 2/5 → q=0, r=2.
  - 0/7 → q=0, r=0.
  - 15/15 → q=1, r=0.
- A=9, B=0:
  - `done` on the cycle after the start edge, with `busy` never high.
  - q=15, r=9, div_by_zero=1.
  - A following 8/2 gives q=4, r=0 and clears div_by_zero.
- Protocol robustness:
  - Start 12/5, then on the next cycle pulse `start` with 7/7 while busy and change A and B.
  - Result must be q=2, r=2, with exactly one `done`.
  - No second operation starts.
- Reset mid-operation:
  - Assert `reset` asynchronously (between edges) two cycles into a 14/3 run.
  - All outputs go to 0 immediately and no `done` appears.
  - After release, 14/3 → q=4, r=2.
- Exhaustive sweep of all 256 (A,B) pairs, back-to-back:
  - For B≠0, check against a reference `/` and `%`.
  - For B=0, check the div-by-zero values.
  - Check `done` count = 256 and a latency of exactly 5 cycles (1 cycle for B=0).
